micro_fetch_decode: RTL
=======================

# micro_fetch_decode

Microcode fetch/decode sequencer: the producer side of the decode pipeline register. Holds the micro program counter, fetches 32-bit microwords from the microcode ROM over a req/valid handshake, decodes them, and drives the `*_md` field/control bus consumed by `mdecode_reg`. Branches, stalls from downstream and halt are handled here.

## Interface
Parameters:
- `MWORD_WIDTH`, 32, microword width
- `BRANCH_ADDR_WIDTH`, 10, micro PC / ROM address width
- `IMM_WIDTH`, 11, immediate width
- `ALU_OPS`, 8, ALU op count (`alu_op_md` is `$clog2(ALU_OPS)` bits)

Ports:
- `sys_clk` in 1: clock
- `sys_reset` in 1: synchronous, active-high reset (one clock, `sys_clk`; reset synchronous active-high)
- `start` in 1: leave IDLE and begin fetching at upc 0
- `rom_req` out 1: fetch request, held until `rom_valid`
- `rom_addr` out 10: microword address (= upc)
- `rom_valid` in 1: `rom_data` valid; may assert in same cycle as `rom_req`
- `rom_data` in 32: microword
- `alu_zero` in 1: zero flag for BRZ, sampled on the fetch-accept cycle
- `md_stall` in 1: downstream stall; hold current issue
- `md_valid` out 1: `*_md` bus carries a real instruction
- `reg_src_md`, `reg_dst_md` out 4; `imm_md` out 11; `branch_target_md` out 10
- `is_imm_active_md`, `alu_en_md`, `reg_file_en_md`, `reg_file_rw_md`, `mem_en_md`, `mem_rw_md`, `is_branch_md` out 1; `alu_op_md` out 3
- `halted` out 1: HALT executed

## Operation
- Microword: [31:29] opcode, [28:25] dst, [24:21] src, [20:18] alu_op, [17:11] reserved (ignored), [10:0] imm; branch target = [9:0].
- Opcodes: 0 NOP (all enables 0); 1 ALU (alu_en, reg_file_en, rw=1); 2 ALUI (as ALU + is_imm_active); 3 LOAD (mem_en, mem_rw=0, reg_file_en, rw=1); 4 STORE (mem_en, mem_rw=1, reg_file_en, rw=0); 5 JMP (is_branch=1); 6 BRZ (is_branch = alu_zero); 7 HALT.
- Field outputs (src/dst/imm/alu_op/target) always carry the raw fields of the accepted word.
- Read = 0, write = 1 for both `reg_file_rw_md` and `mem_rw_md`.
- FSM: IDLE -> (start) FETCH -> (rom_valid) ISSUE -> (!md_stall) FETCH; ISSUE with HALT opcode -> HALT; HALT exits only via reset. `start` ignored outside IDLE.
- Next upc on leaving ISSUE: target if `is_branch_md`, else upc+1 modulo 1024 (0x3FF -> 0x000).
- Whenever `md_valid`=0, all enable/control outputs are 0 (bubble); field outputs hold last value.

## Timing
- Reset: state IDLE, upc 0, `rom_req`=0, `rom_addr`=0, `md_valid`=0, all `*_md`=0, `halted`=0. Reset in any state (including mid-FETCH with req outstanding) takes effect next edge; late `rom_valid` ignored.
- FETCH: `rom_req`=1, `rom_addr`=upc, combinational from state/upc. Edge with `rom_valid`: decoded outputs registered, `md_valid`=1 next cycle.
- ISSUE: outputs stable and `md_valid`=1 for every cycle `md_stall`=1; `rom_req`=0. First non-stalled ISSUE cycle is the consumption cycle; next cycle FETCH with `md_valid`=0.
- Best-case throughput: 1 instruction per 2 cycles (zero-latency ROM).
- HALT word: ISSUE cycle shows bubble controls, `md_valid`=0; `halted`=1 from next cycle, `rom_req` stays 0.

## Structure
- `micro_pkg`: opcode enum, FSM state enum, field bit positions, `REG_FILE_READ/WRITE`, `MEM_READ/WRITE` constants; shared with `mdecode_reg`/`micro_reg_file`.
- Sub-module `micro_inst_decode`: combinational microword -> control/field decode; top holds FSM, upc, output registers.

## Test plan
- Reset, start, ROM returns 0x26A80000 -> md_valid=1, dst=3, src=5, alu_op=2, alu_en=reg_file_en=rw=1; next `rom_addr`=0x001.
- Word 0xA0000155 (JMP) -> is_branch=1, branch_target=0x155; next `rom_addr`=0x155.
- BRZ 0xC0000020 with alu_zero=0 -> is_branch=0, next addr upc+1; repeat with alu_zero=1 -> next addr 0x020.
- md_stall high 3 cycles during ISSUE -> outputs/md_valid stable, rom_req=0 throughout; fetch resumes cycle after release.
- NOP at upc 0x3FF -> next `rom_addr`=0x000.
- HALT 0xE0000000 -> halted=1, rom_req stays 0, start ignored; separately assert sys_reset while rom_req=1 with rom_valid withheld -> rom_req=0 and all outputs 0 next cycle.

Source files
------------

// File: rtl/micro_pkg.sv
// Shared microcode definitions: opcode and sequencer-state encodings, microword
// field positions, and read/write polarity constants for the decode pipeline.
package micro_pkg;

  typedef enum logic [2:0] {
    OP_NOP   = 3'd0,
    OP_ALU   = 3'd1,
    OP_ALUI  = 3'd2,
    OP_LOAD  = 3'd3,
    OP_STORE = 3'd4,
    OP_JMP   = 3'd5,
    OP_BRZ   = 3'd6,
    OP_HALT  = 3'd7
  } opcode_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_ISSUE = 2'd2,
    ST_HALT  = 2'd3
  } state_e;

  localparam int OPC_LSB   = 29;
  localparam int DST_LSB   = 25;
  localparam int SRC_LSB   = 21;
  localparam int ALUOP_LSB = 18;
  localparam int IMM_LSB   = 0;
  localparam int TGT_LSB   = 0;
  localparam int REG_W     = 4;

  localparam logic REG_FILE_READ  = 1'b0;
  localparam logic REG_FILE_WRITE = 1'b1;
  localparam logic MEM_READ       = 1'b0;
  localparam logic MEM_WRITE      = 1'b1;

  typedef struct packed {
    logic is_imm_active;
    logic alu_en;
    logic reg_file_en;
    logic reg_file_rw;
    logic mem_en;
    logic mem_rw;
    logic is_branch;
  } ctrl_t;

endpackage

// File: rtl/micro_inst_decode.sv
// Combinational microword decode: splits the raw fields out and derives the
// control enables for the opcode (BRZ resolves against the supplied zero flag).
module micro_inst_decode
  import micro_pkg::*;
#(
  parameter int MWORD_WIDTH       = 32,
  parameter int BRANCH_ADDR_WIDTH = 10,
  parameter int IMM_WIDTH         = 11,
  parameter int ALU_OP_WIDTH      = 3
) (
  input  logic [MWORD_WIDTH-1:0]       mword,
  input  logic                         alu_zero,
  output logic [REG_W-1:0]             dst,
  output logic [REG_W-1:0]             src,
  output logic [ALU_OP_WIDTH-1:0]      alu_op,
  output logic [IMM_WIDTH-1:0]         imm,
  output logic [BRANCH_ADDR_WIDTH-1:0] target,
  output ctrl_t                        ctrl,
  output logic                         is_halt
);

  opcode_e opcode;
  logic    unused_reserved;

  assign opcode          = opcode_e'(mword[OPC_LSB +: 3]);
  assign dst             = mword[DST_LSB +: REG_W];
  assign src             = mword[SRC_LSB +: REG_W];
  assign alu_op          = mword[ALUOP_LSB +: ALU_OP_WIDTH];
  assign imm             = mword[IMM_LSB +: IMM_WIDTH];
  assign target          = mword[TGT_LSB +: BRANCH_ADDR_WIDTH];
  assign is_halt         = (opcode == OP_HALT);
  assign unused_reserved = ^mword[17:11];

  always_comb begin
    ctrl = '0;
    case (opcode)
      OP_ALU: begin
        ctrl.alu_en      = 1'b1;
        ctrl.reg_file_en = 1'b1;
        ctrl.reg_file_rw = REG_FILE_WRITE;
      end
      OP_ALUI: begin
        ctrl.is_imm_active = 1'b1;
        ctrl.alu_en        = 1'b1;
        ctrl.reg_file_en   = 1'b1;
        ctrl.reg_file_rw   = REG_FILE_WRITE;
      end
      OP_LOAD: begin
        ctrl.mem_en      = 1'b1;
        ctrl.mem_rw      = MEM_READ;
        ctrl.reg_file_en = 1'b1;
        ctrl.reg_file_rw = REG_FILE_WRITE;
      end
      OP_STORE: begin
        ctrl.mem_en      = 1'b1;
        ctrl.mem_rw      = MEM_WRITE;
        ctrl.reg_file_en = 1'b1;
        ctrl.reg_file_rw = REG_FILE_READ;
      end
      OP_JMP:  ctrl.is_branch = 1'b1;
      OP_BRZ:  ctrl.is_branch = alu_zero;
      default: ctrl = '0;
    endcase
  end

endmodule

// File: rtl/micro_fetch_decode.sv
// Microcode sequencer: owns the micro PC, fetches words over rom_req/rom_valid,
// and registers the decoded word onto the *_md bus for the decode pipeline.
// Handshakes: a ROM fetch completes on any edge where rom_req && rom_valid;
// an issued word is consumed on the first ISSUE edge with md_valid && !md_stall.
module micro_fetch_decode
  import micro_pkg::*;
#(
  parameter int MWORD_WIDTH       = 32,
  parameter int BRANCH_ADDR_WIDTH = 10,
  parameter int IMM_WIDTH         = 11,
  parameter int ALU_OPS           = 8
) (
  input  logic                            sys_clk,
  input  logic                            sys_reset,
  input  logic                            start,
  output logic                            rom_req,
  output logic [BRANCH_ADDR_WIDTH-1:0]    rom_addr,
  input  logic                            rom_valid,
  input  logic [MWORD_WIDTH-1:0]          rom_data,
  input  logic                            alu_zero,
  input  logic                            md_stall,
  output logic                            md_valid,
  output logic [REG_W-1:0]                reg_src_md,
  output logic [REG_W-1:0]                reg_dst_md,
  output logic [IMM_WIDTH-1:0]            imm_md,
  output logic [BRANCH_ADDR_WIDTH-1:0]    branch_target_md,
  output logic                            is_imm_active_md,
  output logic                            alu_en_md,
  output logic                            reg_file_en_md,
  output logic                            reg_file_rw_md,
  output logic                            mem_en_md,
  output logic                            mem_rw_md,
  output logic                            is_branch_md,
  output logic [$clog2(ALU_OPS)-1:0]      alu_op_md,
  output logic                            halted,
  output logic [1:0]                      state_dbg
);

  localparam int AW = $clog2(ALU_OPS);

  state_e                       state_q, state_d;
  logic [BRANCH_ADDR_WIDTH-1:0] upc_q, upc_d;
  logic                         md_valid_q, md_valid_d;
  logic                         halt_pend_q, halt_pend_d;
  logic                         halted_q, halted_d;
  ctrl_t                        ctrl_q, ctrl_d;
  logic [REG_W-1:0]             src_q, src_d, dst_q, dst_d;
  logic [AW-1:0]                alu_op_q, alu_op_d;
  logic [IMM_WIDTH-1:0]         imm_q, imm_d;
  logic [BRANCH_ADDR_WIDTH-1:0] tgt_q, tgt_d;

  logic [REG_W-1:0]             dec_src, dec_dst;
  logic [AW-1:0]                dec_alu_op;
  logic [IMM_WIDTH-1:0]         dec_imm;
  logic [BRANCH_ADDR_WIDTH-1:0] dec_tgt;
  ctrl_t                        dec_ctrl;
  logic                         dec_is_halt;

  micro_inst_decode #(
    .MWORD_WIDTH      (MWORD_WIDTH),
    .BRANCH_ADDR_WIDTH(BRANCH_ADDR_WIDTH),
    .IMM_WIDTH        (IMM_WIDTH),
    .ALU_OP_WIDTH     (AW)
  ) u_decode (
    .mword   (rom_data),
    .alu_zero(alu_zero),
    .dst     (dec_dst),
    .src     (dec_src),
    .alu_op  (dec_alu_op),
    .imm     (dec_imm),
    .target  (dec_tgt),
    .ctrl    (dec_ctrl),
    .is_halt (dec_is_halt)
  );

  always_comb begin
    state_d     = state_q;
    upc_d       = upc_q;
    md_valid_d  = md_valid_q;
    halt_pend_d = halt_pend_q;
    halted_d    = halted_q;
    ctrl_d      = ctrl_q;
    src_d       = src_q;
    dst_d       = dst_q;
    alu_op_d    = alu_op_q;
    imm_d       = imm_q;
    tgt_d       = tgt_q;
    case (state_q)
      ST_IDLE: if (start) state_d = ST_FETCH;
      ST_FETCH: begin
        if (rom_valid) begin
          state_d     = ST_ISSUE;
          src_d       = dec_src;
          dst_d       = dec_dst;
          alu_op_d    = dec_alu_op;
          imm_d       = dec_imm;
          tgt_d       = dec_tgt;
          ctrl_d      = dec_ctrl;
          // A HALT word occupies one ISSUE cycle as a bubble, never as valid.
          md_valid_d  = !dec_is_halt;
          halt_pend_d = dec_is_halt;
        end
      end
      ST_ISSUE: begin
        if (halt_pend_q) begin
          state_d     = ST_HALT;
          halt_pend_d = 1'b0;
          halted_d    = 1'b1;
        end else if (!md_stall) begin
          state_d    = ST_FETCH;
          upc_d      = ctrl_q.is_branch ? tgt_q : upc_q + BRANCH_ADDR_WIDTH'(1);
          md_valid_d = 1'b0;
          ctrl_d     = '0;
        end
      end
      default: state_d = ST_HALT;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (sys_reset) begin
      state_q     <= ST_IDLE;
      upc_q       <= '0;
      md_valid_q  <= 1'b0;
      halt_pend_q <= 1'b0;
      halted_q    <= 1'b0;
      ctrl_q      <= '0;
      src_q       <= '0;
      dst_q       <= '0;
      alu_op_q    <= '0;
      imm_q       <= '0;
      tgt_q       <= '0;
    end else begin
      state_q     <= state_d;
      upc_q       <= upc_d;
      md_valid_q  <= md_valid_d;
      halt_pend_q <= halt_pend_d;
      halted_q    <= halted_d;
      ctrl_q      <= ctrl_d;
      src_q       <= src_d;
      dst_q       <= dst_d;
      alu_op_q    <= alu_op_d;
      imm_q       <= imm_d;
      tgt_q       <= tgt_d;
    end
  end

  assign rom_req          = (state_q == ST_FETCH);
  assign rom_addr         = upc_q;
  assign md_valid         = md_valid_q;
  assign reg_src_md       = src_q;
  assign reg_dst_md       = dst_q;
  assign alu_op_md        = alu_op_q;
  assign imm_md           = imm_q;
  assign branch_target_md = tgt_q;
  assign is_imm_active_md = ctrl_q.is_imm_active;
  assign alu_en_md        = ctrl_q.alu_en;
  assign reg_file_en_md   = ctrl_q.reg_file_en;
  assign reg_file_rw_md   = ctrl_q.reg_file_rw;
  assign mem_en_md        = ctrl_q.mem_en;
  assign mem_rw_md        = ctrl_q.mem_rw;
  assign is_branch_md     = ctrl_q.is_branch;
  assign halted           = halted_q;
  assign state_dbg        = state_q;

endmodule
